riscv_mc_core: RTL and testbench
================================

RISCV_MC_CORE -- requirements
Module: riscv_mc_core

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning the register count: 32 for RV32I, 16 for RV32E; other values are illegal.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 0, meaning the maximum wait cycles per memory request; 0 disables the timeout.
REQ-004 SHALL be clocked by clk (input, 1 bit), the single clock; all state updates on its rising edge.
REQ-005 SHALL have rst_n (input, 1 bit): asynchronous, active-low reset.
REQ-006 SHALL have mem_req (output, 1 bit): memory request valid.
REQ-007 SHALL have mem_we (output, 1 bit): request is a write.
REQ-008 SHALL have mem_addr (output, 32 bits): byte address, always word-aligned (bits [1:0] = 0).
REQ-009 SHALL have mem_wdata (output, 32 bits): write data, lane-aligned.
REQ-010 SHALL have mem_wstrb (output, 4 bits): byte write enables.
REQ-011 SHALL have mem_ready (input, 1 bit): the request completes in any cycle where mem_req and mem_ready are both 1.
REQ-012 SHALL have mem_rdata (input, 32 bits): read data, valid in the completing cycle.
REQ-013 SHALL have retire (output, 1 bit): one-cycle pulse per completed instruction.
REQ-014 SHALL have trap (output, 1 bit): sticky; the core has stopped on an exception.
REQ-015 SHALL have trap_cause (output, 3 bits): 1 illegal instruction, 2 fetch misaligned, 3 load/store misaligned, 4 ECALL, 5 EBREAK, 6 memory timeout.

Function
REQ-016 SHALL implement a single-issue FSM with states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-017 FETCH SHALL hold mem_req=1, mem_we=0 and mem_addr=pc until completion, latch mem_rdata as the instruction, then go to DECODE.
REQ-018 DECODE SHALL read rs1/rs2, form the I/S/B/U/J immediates sign-extended to 32 bits, detect illegal encodings, then go to EXEC.
REQ-019 EXEC SHALL compute the ALU result, branch condition and target, then go to MEM for LOAD/STORE and to WB otherwise.
REQ-020 MEM SHALL hold mem_req with mem_addr={ea[31:2],2'b00} until completion; mem_we, mem_wstrb and mem_wdata stay stable for the whole request.
REQ-021 WB SHALL write rd (never x0), update pc, pulse retire for one cycle, then return to FETCH.
REQ-022 With mem_ready tied to 1, latency SHALL be 4 cycles for non-memory instructions and 5 cycles for LOAD/STORE; each wait cycle adds exactly 1.
REQ-023 SHALL support the full RV32I base set except FENCE/CSR; FENCE SHALL execute as a NOP, and CSR opcodes SHALL be illegal.
REQ-024 SUB and SRA/SRAI SHALL be selected by funct7[5], and SRA SHALL shift arithmetically.
REQ-025 SLT/SLTI SHALL compute signed rs1<op2, and SLTU/SLTIU SHALL compute unsigned rs1<op2.
REQ-026 Shift amounts SHALL use the low 5 bits only; SLLI/SRLI/SRAI with illegal funct7 SHALL be illegal.
REQ-027 Stores SHALL replicate data per lane: SB wstrb=4'b0001<<ea[1:0]; SH wstrb=4'b0011<<ea[1:0] (ea[1] selects the half-word); SW wstrb=4'b1111.
REQ-028 Loads SHALL extract LB, LBU, LH, LHU and LW by ea[1:0], with sign- or zero-extension.
REQ-029 LH/LHU/SH with ea[0]=1, or LW/SW with ea[1:0]!=0, SHALL trap with cause 3, issue no memory request and make no register write.
REQ-030 A taken branch or jump to a target with bits [1:0]!=0 SHALL trap with cause 2, leaving pc unchanged.
REQ-031 JALR target SHALL be (rs1+imm) & ~1; JAL/JALR SHALL write pc+4 to rd.
REQ-032 With NUM_REGS=16, any rd/rs1/rs2 index >=16 SHALL trap with cause 1.
REQ-033 On any trap: enter HALT, set trap=1 and trap_cause, leave pc at the faulting instruction, deassert mem_req and do not pulse retire; HALT is left only by reset.
REQ-034 If MEM_TIMEOUT>0 and a request waits MEM_TIMEOUT cycles without mem_ready, SHALL trap with cause 6.
REQ-035 Reading x0 SHALL always return 0.

Reset
REQ-036 While rst_n=0 (asynchronous assertion): state=FETCH, pc=RESET_PC, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, retire=0, trap=0, trap_cause=0, timeout counter=0.
REQ-037 Register-file contents SHALL be undefined after reset, except x0=0.
REQ-038 Reset asserted mid-request SHALL drop mem_req immediately; the first request after deassertion SHALL be the fetch from RESET_PC.

Verification
REQ-039 Bench SHALL cover: ADDI x1,x0,-5; SLTI x2,x1,1; SRAI x3,x1,1 -> x1=0xFFFFFFFB, x2=1, x3=0xFFFFFFFD; 4 cycles per instruction with mem_ready=1.
REQ-040 Bench SHALL cover: x5=0x100, x6=0xA1B2C3D4; SB x6,3(x5) -> addr 0x100, wstrb 4'b1000, wdata[31:24]=0xD4; LB x7,3(x5) -> x7=0xFFFFFFD4.
REQ-041 Bench SHALL cover: mem_ready held low 3 cycles during FETCH -> mem_req/mem_addr stable; instruction retires 3 cycles later than zero-wait.
REQ-042 Bench SHALL cover: LW from 0x102 -> trap=1, trap_cause=3, no mem_req for the load, pc unchanged, no retire.
REQ-043 Bench SHALL cover: BNE x0,x1,+8 with x1=1 at pc 0x20 -> next fetch address 0x28; JALR x1,0(x2) with x2=0x41 -> pc=0x40, x1=return address.
REQ-044 Bench SHALL cover: rst_n pulsed low mid-MEM store -> mem_req=0 within the same cycle; after release, first fetch at RESET_PC with trap=0.

Source files
------------

// File: rtl/riscv_mc_core.sv
// Multi-cycle RV32I/RV32E core: one instruction in flight, one shared memory
// port for fetch and data, stops in HALT on the first exception.
module riscv_mc_core #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          NUM_REGS    = 32,
  parameter int          MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        retire,
  output logic        trap,
  output logic [2:0]  trap_cause
);
  localparam int AW = (NUM_REGS == 16) ? 4 : 5;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_IMM = 7'h13;
  localparam logic [6:0] OP_REG = 7'h33, OP_FENCE = 7'h0F, OP_SYS = 7'h73;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state_reg, state_next;

  logic [31:0] pc_reg, instr_reg, rs1_val_reg, rs2_val_reg, result_reg, npc_reg, ea_reg, wdata_reg;
  logic [31:0] wait_cnt_reg;
  logic [3:0]  wstrb_reg;
  logic        trap_reg;
  logic [2:0]  cause_reg, cause_next;
  logic [31:0] regs [NUM_REGS];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign opcode = instr_reg[6:0];
  assign rd     = instr_reg[11:7];
  assign f3     = instr_reg[14:12];
  assign rs1    = instr_reg[19:15];
  assign rs2    = instr_reg[24:20];
  assign f7     = instr_reg[31:25];
  assign imm_i  = {{20{instr_reg[31]}}, instr_reg[31:20]};
  assign imm_s  = {{20{instr_reg[31]}}, instr_reg[31:25], instr_reg[11:7]};
  assign imm_b  = {{19{instr_reg[31]}}, instr_reg[31], instr_reg[7], instr_reg[30:25], instr_reg[11:8], 1'b0};
  assign imm_u  = {instr_reg[31:12], 12'b0};
  assign imm_j  = {{11{instr_reg[31]}}, instr_reg[31], instr_reg[19:12], instr_reg[20], instr_reg[30:21], 1'b0};

  logic is_load, is_store, is_reg;
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_reg   = (opcode == OP_REG);

  logic illegal, is_ecall, is_ebreak, uses_rd, uses_rs1, uses_rs2;
  always_comb begin
    illegal = 1'b0; is_ecall = 1'b0; is_ebreak = 1'b0;
    uses_rd = 1'b0; uses_rs1 = 1'b0; uses_rs2 = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: uses_rd = 1'b1;
      OP_JALR:  begin uses_rd = 1'b1; uses_rs1 = 1'b1; illegal = (f3 != 3'd0); end
      OP_BR:    begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; illegal = (f3[2:1] == 2'b01); end
      OP_LOAD:  begin uses_rd = 1'b1; uses_rs1 = 1'b1; illegal = (f3 == 3'd3) || (f3[2:1] == 2'b11); end
      OP_STORE: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; illegal = f3[2] || (f3 == 3'd3); end
      OP_IMM: begin
        uses_rd = 1'b1; uses_rs1 = 1'b1;
        if (f3 == 3'd1) illegal = (f7 != 7'h00);
        if (f3 == 3'd5) illegal = (f7 != 7'h00) && (f7 != 7'h20);
      end
      OP_REG: begin
        uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        illegal = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      OP_FENCE: ;
      OP_SYS: begin
        if (instr_reg == 32'h0000_0073)      is_ecall = 1'b1;
        else if (instr_reg == 32'h0010_0073) is_ebreak = 1'b1;
        else                                 illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // RV32E only has x0..x15; any wider index in a used field is illegal
    if (NUM_REGS == 16 && ((uses_rd && rd[4]) || (uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4])))
      illegal = 1'b1;
  end

  logic [31:0] op2, alu_out, exec_result, ea, target, npc, st_data, load_data, lshift;
  logic [3:0]  st_strb;
  logic        taken, redirect, fetch_misalign, mem_misalign;
  assign op2 = is_reg ? rs2_val_reg : imm_i;
  assign ea  = rs1_val_reg + (is_store ? imm_s : imm_i);

  always_comb begin
    case (f3)
      3'd0:    alu_out = (is_reg && f7[5]) ? rs1_val_reg - op2 : rs1_val_reg + op2;
      3'd1:    alu_out = rs1_val_reg << op2[4:0];
      3'd2:    alu_out = {31'b0, $signed(rs1_val_reg) < $signed(op2)};
      3'd3:    alu_out = {31'b0, rs1_val_reg < op2};
      3'd4:    alu_out = rs1_val_reg ^ op2;
      3'd5:    alu_out = f7[5] ? 32'($signed(rs1_val_reg) >>> op2[4:0]) : rs1_val_reg >> op2[4:0];
      3'd6:    alu_out = rs1_val_reg | op2;
      default: alu_out = rs1_val_reg & op2;
    endcase
    case (opcode)
      OP_LUI:          exec_result = imm_u;
      OP_AUIPC:        exec_result = pc_reg + imm_u;
      OP_JAL, OP_JALR: exec_result = pc_reg + 32'd4;
      default:         exec_result = alu_out;
    endcase
    case (f3)
      3'd0:    taken = (rs1_val_reg == rs2_val_reg);
      3'd1:    taken = (rs1_val_reg != rs2_val_reg);
      3'd4:    taken = ($signed(rs1_val_reg) < $signed(rs2_val_reg));
      3'd5:    taken = ($signed(rs1_val_reg) >= $signed(rs2_val_reg));
      3'd6:    taken = (rs1_val_reg < rs2_val_reg);
      default: taken = (rs1_val_reg >= rs2_val_reg);
    endcase
    case (opcode)
      OP_JAL:  target = pc_reg + imm_j;
      OP_JALR: target = (rs1_val_reg + imm_i) & ~32'd1;
      default: target = pc_reg + imm_b;
    endcase
    redirect       = (opcode == OP_JAL) || (opcode == OP_JALR) || ((opcode == OP_BR) && taken);
    npc            = redirect ? target : pc_reg + 32'd4;
    fetch_misalign = redirect && (target[1:0] != 2'b00);
    mem_misalign   = (is_load || is_store) &&
                     ((f3[1:0] == 2'b01 && ea[0]) || (f3[1:0] == 2'b10 && ea[1:0] != 2'b00));
    case (f3[1:0])
      2'b00:   begin st_data = {4{rs2_val_reg[7:0]}};  st_strb = 4'b0001 << ea[1:0]; end
      2'b01:   begin st_data = {2{rs2_val_reg[15:0]}}; st_strb = 4'b0011 << ea[1:0]; end
      default: begin st_data = rs2_val_reg;            st_strb = 4'b1111;          end
    endcase
    lshift = mem_rdata >> {ea_reg[1:0], 3'b000};
    case (f3)
      3'd0:    load_data = {{24{lshift[7]}}, lshift[7:0]};
      3'd1:    load_data = {{16{lshift[15]}}, lshift[15:0]};
      3'd4:    load_data = {24'b0, lshift[7:0]};
      3'd5:    load_data = {16'b0, lshift[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  logic req_int, timeout;
  assign req_int = (state_reg == FETCH) || (state_reg == MEM);
  assign timeout = (MEM_TIMEOUT > 0) && req_int && !mem_ready &&
                   (wait_cnt_reg == 32'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= FETCH;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cause_next = 3'd0;
    case (state_reg)
      FETCH: begin
        if (timeout)        begin state_next = HALT; cause_next = 3'd6; end
        else if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        if (illegal)        begin state_next = HALT; cause_next = 3'd1; end
        else if (is_ecall)  begin state_next = HALT; cause_next = 3'd4; end
        else if (is_ebreak) begin state_next = HALT; cause_next = 3'd5; end
        else                state_next = EXEC;
      end
      EXEC: begin
        if (fetch_misalign)          begin state_next = HALT; cause_next = 3'd2; end
        else if (mem_misalign)       begin state_next = HALT; cause_next = 3'd3; end
        else if (is_load || is_store) state_next = MEM;
        else                         state_next = WB;
      end
      MEM: begin
        if (timeout)        begin state_next = HALT; cause_next = 3'd6; end
        else if (mem_ready) state_next = WB;
      end
      WB:      state_next = FETCH;
      default: state_next = HALT;
    endcase
  end

  // Outputs are gated by rst_n so a reset drops the bus in the same cycle
  always_comb begin
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'd0;
    retire  = 1'b0;
    if (rst_n) begin
      case (state_reg)
        FETCH: begin mem_req = 1'b1; mem_addr = {pc_reg[31:2], 2'b00}; end
        MEM: begin
          mem_req  = 1'b1;
          mem_we   = is_store;
          mem_addr = {ea_reg[31:2], 2'b00};
          if (is_store) begin mem_wdata = wdata_reg; mem_wstrb = wstrb_reg; end
        end
        WB:      retire = 1'b1;
        default: ;
      endcase
    end
  end
  assign trap       = trap_reg;
  assign trap_cause = cause_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC; instr_reg <= '0; rs1_val_reg <= '0; rs2_val_reg <= '0;
      result_reg <= '0; npc_reg <= '0; ea_reg <= '0; wdata_reg <= '0; wstrb_reg <= '0;
      wait_cnt_reg <= '0; trap_reg <= 1'b0; cause_reg <= 3'd0;
    end else begin
      wait_cnt_reg <= (req_int && !mem_ready) ? wait_cnt_reg + 32'd1 : 32'd0;
      case (state_reg)
        FETCH:  if (mem_ready) instr_reg <= mem_rdata;
        DECODE: begin
          rs1_val_reg <= (rs1 == 5'd0) ? 32'd0 : regs[rs1[AW-1:0]];
          rs2_val_reg <= (rs2 == 5'd0) ? 32'd0 : regs[rs2[AW-1:0]];
        end
        EXEC: begin
          result_reg <= exec_result; npc_reg <= npc; ea_reg <= ea;
          wdata_reg  <= st_data;     wstrb_reg <= st_strb;
        end
        MEM:     if (mem_ready && is_load) result_reg <= load_data;
        WB:      pc_reg <= npc_reg;
        default: ;
      endcase
      if (state_next == HALT && state_reg != HALT) begin
        trap_reg  <= 1'b1;
        cause_reg <= cause_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_reg == WB && uses_rd && rd != 5'd0) regs[rd[AW-1:0]] <= result_reg;
  end
endmodule

// File: tb/tb_riscv_mc_core.sv
// Directed bench for riscv_mc_core: small hand-assembled programs run against a
// word memory model; results are stored to memory and compared there.
module tb_riscv_mc_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_we, mem_ready, retire, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [2:0]  trap_cause;

  always #5 clk = ~clk;

  riscv_mc_core dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .retire(retire), .trap(trap), .trap_cause(trap_cause)
  );

  localparam logic [6:0] LUI = 7'h37, LOAD = 7'h03, IMM = 7'h13, JALR = 7'h67;
  localparam logic [31:0] ECALL = 32'h0000_0073, EBREAK = 32'h0010_0073;

  logic [31:0] mem [256];
  logic        mem_clr, ld_en, hold_wr;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data, stall_addr;
  int          stall_until, stall_cnt, cyc;
  int          retire_q[$];
  logic [31:0] rd_q[$], wr_addr_q[$], wr_data_q[$], wr_strb_q[$], stall_q[$];

  logic stalling;
  assign stalling  = mem_req && !mem_we && mem_addr == stall_addr && stall_cnt < stall_until;
  assign mem_ready = !(stalling || (hold_wr && mem_we));
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stalling) stall_cnt <= stall_cnt + 1;
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_req && mem_ready && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    if (retire) retire_q.push_back(cyc);
    if (mem_req && !mem_ready) stall_q.push_back(mem_addr);
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        wr_addr_q.push_back(mem_addr); wr_data_q.push_back(mem_wdata); wr_strb_q.push_back(32'(mem_wstrb));
        $display("[%0d] write addr=%08h strb=%b data=%08h", cyc, mem_addr, mem_wstrb, mem_wdata);
      end else begin
        rd_q.push_back(mem_addr);
        $display("[%0d] read  addr=%08h data=%08h", cyc, mem_addr, mem_rdata);
      end
    end
  end

  int n_cmp, n_bad;
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_u(input int imm, input int rd, input logic [6:0] op);
    return {imm[19:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction

  int rq_base, rd_base, wr_base, st_base, c0;

  task automatic start_test();
    @(negedge clk);
    rst_n = 1'b0; hold_wr = 1'b0; stall_until = stall_cnt; mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
  endtask
  task automatic put(input int addr, input logic [31:0] w);
    ld_en = 1'b1; ld_addr = addr[9:2]; ld_data = w;
    @(negedge clk);
    ld_en = 1'b0;
  endtask
  task automatic go();
    rq_base = retire_q.size(); rd_base = rd_q.size(); wr_base = wr_addr_q.size();
    st_base = stall_q.size(); c0 = cyc;
    rst_n = 1'b1;
  endtask
  task automatic wait_trap(input string tag);
    int n = 0;
    while (!trap && n < 400) begin @(negedge clk); n++; end
    check_eq(tag, 32'(trap), 32'd1);
  endtask

  initial begin
    mem_clr = 1'b0; ld_en = 1'b0; hold_wr = 1'b0; ld_addr = 8'd0; ld_data = 32'd0;
    stall_addr = 32'hFFFF_FFFF; stall_until = 0;

    // ALU: signed/unsigned compares, arithmetic shift, SUB, LUI
    start_test();
    put(32'h00, enc_i(-5, 0, 0, 1, IMM));
    put(32'h04, enc_i(1, 1, 2, 2, IMM));
    put(32'h08, enc_i(32'h401, 1, 5, 3, IMM));
    put(32'h0C, enc_i(1, 1, 3, 4, IMM));
    put(32'h10, enc_r(32'h20, 1, 0, 0, 5));
    put(32'h14, enc_u(32'h12345, 6, LUI));
    for (int i = 0; i < 6; i++) put(32'h18 + 4 * i, enc_s(32'h200 + 4 * i, i + 1, 0, 2));
    put(32'h30, ECALL);
    check_eq("rst mem_req", 32'(mem_req), 32'd0);
    check_eq("rst mem_addr", mem_addr, 32'd0);
    check_eq("rst we/strb/wdata", {mem_wdata[30:0] | 31'(mem_wstrb), mem_we}, 32'd0);
    check_eq("rst retire/trap", {29'd0, retire, trap, |trap_cause}, 32'd0);
    go();
    wait_trap("s1 trap");
    check_eq("s1 cause ecall", 32'(trap_cause), 32'd4);
    check_eq("s1 retires", 32'(retire_q.size() - rq_base), 32'd12);
    check_eq("s1 first latency", 32'(retire_q[rq_base] - c0), 32'd3);
    check_eq("s1 addi->slti cycles", 32'(retire_q[rq_base + 1] - retire_q[rq_base]), 32'd4);
    check_eq("s1 slti->srai cycles", 32'(retire_q[rq_base + 2] - retire_q[rq_base + 1]), 32'd4);
    check_eq("s1 sw cycles", 32'(retire_q[rq_base + 7] - retire_q[rq_base + 6]), 32'd5);
    check_eq("s1 x1 addi", mem[8'h80], 32'hFFFF_FFFB);
    check_eq("s1 x2 slti", mem[8'h81], 32'h0000_0001);
    check_eq("s1 x3 srai", mem[8'h82], 32'hFFFF_FFFD);
    check_eq("s1 x4 sltiu", mem[8'h83], 32'h0000_0000);
    check_eq("s1 x5 sub", mem[8'h84], 32'h0000_0005);
    check_eq("s1 x6 lui", mem[8'h85], 32'h1234_5000);

    // Sub-word stores and loads with lane replication and extension
    start_test();
    put(32'h00, enc_i(32'h100, 0, 0, 5, IMM));
    put(32'h04, enc_u(32'hA1B2C, 6, LUI));
    put(32'h08, enc_i(32'h3D4, 6, 0, 6, IMM));
    put(32'h0C, enc_s(3, 6, 5, 0));
    put(32'h10, enc_i(3, 5, 0, 7, LOAD));
    put(32'h14, enc_i(3, 5, 4, 8, LOAD));
    put(32'h18, enc_s(2, 6, 5, 1));
    put(32'h1C, enc_i(2, 5, 1, 9, LOAD));
    put(32'h20, enc_i(0, 5, 2, 10, LOAD));
    for (int i = 0; i < 4; i++) put(32'h24 + 4 * i, enc_s(32'h200 + 4 * i, 7 + i, 0, 2));
    put(32'h34, ECALL);
    go();
    wait_trap("s2 trap");
    check_eq("s2 sb addr", wr_addr_q[wr_base], 32'h100);
    check_eq("s2 sb strb", wr_strb_q[wr_base], 32'b1000);
    check_eq("s2 sb wdata", wr_data_q[wr_base], 32'hD4D4_D4D4);
    check_eq("s2 sh strb", wr_strb_q[wr_base + 1], 32'b1100);
    check_eq("s2 sh wdata", wr_data_q[wr_base + 1], 32'hC3D4_C3D4);
    check_eq("s2 lb", mem[8'h80], 32'hFFFF_FFD4);
    check_eq("s2 lbu", mem[8'h81], 32'h0000_00D4);
    check_eq("s2 lh", mem[8'h82], 32'hFFFF_C3D4);
    check_eq("s2 lw", mem[8'h83], 32'hC3D4_0000);

    // Three wait states on the second fetch
    start_test();
    for (int i = 0; i < 3; i++) put(4 * i, enc_i(i + 1, 0, 0, i + 1, IMM));
    put(32'h0C, ECALL);
    stall_addr = 32'h4; stall_until = stall_cnt + 3;
    go();
    wait_trap("s3 trap");
    check_eq("s3 stall cycles", 32'(stall_q.size() - st_base), 32'd3);
    for (int i = 0; i < 3; i++) check_eq("s3 stall addr", stall_q[st_base + i], 32'h4);
    check_eq("s3 stalled latency", 32'(retire_q[rq_base + 1] - retire_q[rq_base]), 32'd7);
    check_eq("s3 next latency", 32'(retire_q[rq_base + 2] - retire_q[rq_base + 1]), 32'd4);

    // Misaligned LW traps before any data request
    start_test();
    put(32'h00, enc_i(32'h102, 0, 0, 1, IMM));
    put(32'h04, enc_i(0, 1, 2, 2, LOAD));
    go();
    wait_trap("s4 trap");
    check_eq("s4 cause", 32'(trap_cause), 32'd3);
    check_eq("s4 requests", 32'(rd_q.size() - rd_base + wr_addr_q.size() - wr_base), 32'd2);
    check_eq("s4 retires", 32'(retire_q.size() - rq_base), 32'd1);
    check_eq("s4 pc", dut.pc_reg, 32'h4);
    check_eq("s4 req idle", 32'(mem_req), 32'd0);

    // JAL, taken BNE and JALR with bit 0 cleared
    start_test();
    put(32'h00, enc_i(1, 0, 0, 1, IMM));
    put(32'h04, enc_j(32'h1C, 0));
    put(32'h20, enc_b(8, 1, 0, 1));
    put(32'h24, ECALL);
    put(32'h28, enc_i(32'h41, 0, 0, 2, IMM));
    put(32'h2C, enc_i(0, 2, 0, 1, JALR));
    put(32'h30, ECALL);
    put(32'h40, enc_s(32'h200, 1, 0, 2));
    put(32'h44, EBREAK);
    go();
    wait_trap("s5 trap");
    check_eq("s5 cause ebreak", 32'(trap_cause), 32'd5);
    check_eq("s5 fetch count", 32'(rd_q.size() - rd_base), 32'd7);
    begin
      logic [31:0] exp_f [7] = '{32'h00, 32'h04, 32'h20, 32'h28, 32'h2C, 32'h40, 32'h44};
      for (int i = 0; i < 7; i++) check_eq("s5 fetch addr", rd_q[rd_base + i], exp_f[i]);
    end
    check_eq("s5 jalr link", mem[8'h80], 32'h30);
    check_eq("s5 pc", dut.pc_reg, 32'h44);

    // JALR to 0x42 is a misaligned fetch target
    start_test();
    put(32'h00, enc_i(32'h42, 0, 0, 1, IMM));
    put(32'h04, enc_i(0, 1, 0, 0, JALR));
    go();
    wait_trap("s6 trap");
    check_eq("s6 cause", 32'(trap_cause), 32'd2);
    check_eq("s6 pc", dut.pc_reg, 32'h4);
    check_eq("s6 retires", 32'(retire_q.size() - rq_base), 32'd1);

    // CSR opcode is illegal
    start_test();
    put(32'h00, 32'h3000_2573);
    go();
    wait_trap("s7 trap");
    check_eq("s7 cause", 32'(trap_cause), 32'd1);
    check_eq("s7 retires", 32'(retire_q.size() - rq_base), 32'd0);

    // Reset in the middle of a held store
    start_test();
    put(32'h00, enc_i(32'h55, 0, 0, 1, IMM));
    put(32'h04, enc_s(32'h200, 1, 0, 2));
    put(32'h08, ECALL);
    hold_wr = 1'b1;
    go();
    begin
      int n = 0;
      while (!(mem_req && mem_we) && n < 100) begin @(negedge clk); n++; end
    end
    check_eq("s8 store pending", 32'(mem_req && mem_we), 32'd1);
    @(negedge clk);
    check_eq("s8 store addr", mem_addr, 32'h200);
    check_eq("s8 store wdata", mem_wdata, 32'h55);
    check_eq("s8 store strb", 32'(mem_wstrb), 32'hF);
    rst_n = 1'b0;
    #1;
    check_eq("s8 req drop", 32'(mem_req), 32'd0);
    hold_wr = 1'b0;
    @(negedge clk);
    go();
    #1;
    check_eq("s8 first req", 32'(mem_req && !mem_we), 32'd1);
    check_eq("s8 first addr", mem_addr, 32'h0);
    check_eq("s8 trap clear", 32'(trap), 32'd0);
    check_eq("s8 no early write", mem[8'h80], 32'd0);
    wait_trap("s8 trap");
    check_eq("s8 rerun store", mem[8'h80], 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end
endmodule
